rs_issue_scheduler: RTL and testbench

Selects which reservation-station entry issues each cycle and tracks functional-unit occupancy. Sits between the reservation station and the issue stage, and replaces "highest ready index wins" with oldest-first selection. Eligibility is gated by multiplier and memory-port availability. Outputs the chosen entry index back to the reservation station, which marks that entry issued and forwards its decoder packet.

---
 rtl/rs_issue_scheduler_pkg.sv | 19 +
 rtl/rs_issue_scheduler_age_matrix.sv | 57 +++++
 rtl/rs_issue_scheduler.sv | 120 ++++++++++++
 tb/tb_rs_issue_scheduler.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/rs_issue_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rs_issue_scheduler_pkg
// Description : Shared functional-unit class encoding and multiplier latency.
// Revision    : 1.0 - initial release
// ============================================================================
package rs_issue_scheduler_pkg;

    typedef enum logic [1:0] {
        FU_ALU  = 2'd0,
        FU_MULT = 2'd1,
        FU_MEM  = 2'd2,
        FU_RSVD = 2'd3
    } fu_type_e;

    localparam int MULT_LAT = 4;

endpackage : rs_issue_scheduler_pkg
`default_nettype wire

// File: rtl/rs_issue_scheduler_age_matrix.sv
`default_nettype none
// ============================================================================
// Module      : age_matrix
// Description : Allocation-order matrix and oldest-requester one-hot select.
// Revision    : 1.0 - initial release
// ============================================================================
module age_matrix #(
    parameter int RS_SZ = 5,
    parameter int IDX_W = $clog2(RS_SZ)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_alloc_en,
    input  logic [IDX_W-1:0] i_alloc_idx,
    input  logic [RS_SZ-1:0] i_req,
    output logic [RS_SZ-1:0] o_grant
);

    // older_q[r][c] = 1 means entry r was allocated before entry c
    logic [RS_SZ-1:0][RS_SZ-1:0] older_q;
    logic [RS_SZ-1:0][RS_SZ-1:0] older_d;
    logic [RS_SZ-1:0][RS_SZ-1:0] w_col;

    always_comb begin
        older_d = older_q;
        for (int r = 0; r < RS_SZ; r++) begin
            for (int c = 0; c < RS_SZ; c++) begin
                if (i_alloc_en) begin
                    if (i_alloc_idx == IDX_W'(r)) begin
                        older_d[r][c] = 1'b0;
                    end else if (i_alloc_idx == IDX_W'(c)) begin
                        older_d[r][c] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            older_q <= '0;
        end else begin
            older_q <= older_d;
        end
    end

    generate
        for (genvar gi = 0; gi < RS_SZ; gi++) begin : g_grant
            for (genvar gj = 0; gj < RS_SZ; gj++) begin : g_col
                assign w_col[gi][gj] = older_q[gj][gi];
            end
            assign o_grant[gi] = i_req[gi] & ~(|(i_req & w_col[gi]));
        end
    endgenerate

endmodule : age_matrix
`default_nettype wire

// File: rtl/rs_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rs_issue_scheduler
// Description : Oldest-first issue select with multiplier/memory occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_issue_scheduler #(
    parameter int RS_SZ    = 5,
    parameter int IDX_W    = $clog2(RS_SZ),
    parameter int MULT_LAT = rs_issue_scheduler_pkg::MULT_LAT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  interrupt,
    input  logic                  is_stall,
    input  logic                  alloc_en,
    input  logic [IDX_W-1:0]      alloc_idx,
    input  logic [RS_SZ-1:0]      ready_vec,
    input  logic [RS_SZ-1:0][1:0] fu_type,
    input  logic                  mem_done,
    output logic                  issue_en,
    output logic [IDX_W-1:0]      issue_idx,
    output logic [1:0]            issue_fu,
    output logic                  mult_busy,
    output logic                  mem_busy
);

    import rs_issue_scheduler_pkg::*;

    localparam int CNT_W = $clog2(MULT_LAT + 1);

    logic [CNT_W-1:0] mult_cnt_q;
    logic [CNT_W-1:0] mult_cnt_d;
    logic             mem_busy_q;
    logic             mem_busy_d;

    logic [RS_SZ-1:0] w_eligible;
    logic [RS_SZ-1:0] w_grant;
    logic [IDX_W-1:0] w_sel_idx;
    logic [1:0]       w_sel_fu;
    logic             w_commit;

    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < RS_SZ; i++) begin
            case (fu_type[i])
                FU_ALU:  w_eligible[i] = ready_vec[i];
                FU_MULT: w_eligible[i] = ready_vec[i] && (mult_cnt_q == '0);
                FU_MEM:  w_eligible[i] = ready_vec[i] && !mem_busy_q;
                default: w_eligible[i] = 1'b0;
            endcase
        end
    end

    age_matrix #(
        .RS_SZ (RS_SZ),
        .IDX_W (IDX_W)
    ) u_age_matrix (
        .i_clk       (clock),
        .i_rst       (reset),
        .i_alloc_en  (alloc_en),
        .i_alloc_idx (alloc_idx),
        .i_req       (w_eligible),
        .o_grant     (w_grant)
    );

    // Lowest index wins only among never-allocated entries sharing equal age
    always_comb begin
        w_sel_idx = '0;
        w_sel_fu  = 2'd0;
        for (int i = RS_SZ - 1; i >= 0; i--) begin
            if (w_grant[i]) begin
                w_sel_idx = IDX_W'(i);
                w_sel_fu  = fu_type[i];
            end
        end
    end

    assign issue_en  = (|w_eligible) && !interrupt;
    assign issue_idx = issue_en ? w_sel_idx : '0;
    assign issue_fu  = issue_en ? w_sel_fu  : 2'd0;
    assign w_commit  = issue_en && !is_stall;

    always_comb begin
        mult_cnt_d = mult_cnt_q;
        if (interrupt) begin
            mult_cnt_d = '0;
        end else if (w_commit && (w_sel_fu == FU_MULT)) begin
            mult_cnt_d = CNT_W'(MULT_LAT);
        end else if (mult_cnt_q != '0) begin
            mult_cnt_d = mult_cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        mem_busy_d = mem_busy_q;
        if (interrupt) begin
            mem_busy_d = 1'b0;
        end else if (w_commit && (w_sel_fu == FU_MEM)) begin
            mem_busy_d = 1'b1;
        end else if (mem_done) begin
            mem_busy_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mult_cnt_q <= '0;
            mem_busy_q <= 1'b0;
        end else begin
            mult_cnt_q <= mult_cnt_d;
            mem_busy_q <= mem_busy_d;
        end
    end

    assign mult_busy = (mult_cnt_q != '0);
    assign mem_busy  = mem_busy_q;

endmodule : rs_issue_scheduler
`default_nettype wire

// File: tb/tb_rs_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs_issue_scheduler
// Description : Directed scoreboard bench for rs_issue_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_issue_scheduler;

    localparam logic [9:0] C_ALU     = 10'b00_00_00_00_00;
    localparam logic [9:0] C_F0_MULT = 10'b00_00_00_00_01;
    localparam logic [9:0] C_F02_MUL = 10'b00_00_01_00_01;
    localparam logic [9:0] C_F2_MEM  = 10'b00_00_10_00_00;
    localparam logic [9:0] C_F1_MEM  = 10'b00_00_00_10_00;
    localparam logic [9:0] C_F2_RSVD = 10'b00_00_11_00_00;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       interrupt = 1'b0;
    logic       is_stall = 1'b0;
    logic       alloc_en = 1'b0;
    logic [2:0] alloc_idx = '0;
    logic [4:0] ready_vec = '0;
    logic [9:0] fu_type = '0;
    logic       mem_done = 1'b0;
    logic       issue_en;
    logic [2:0] issue_idx;
    logic [1:0] issue_fu;
    logic       mult_busy;
    logic       mem_busy;

    typedef struct {
        int         step;
        logic       en;
        logic [2:0] idx;
        logic [1:0] fu;
        logic       mb;
        logic       memb;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_no  = 0;

    rs_issue_scheduler #(
        .RS_SZ    (5),
        .IDX_W    (3),
        .MULT_LAT (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .interrupt (interrupt),
        .is_stall  (is_stall),
        .alloc_en  (alloc_en),
        .alloc_idx (alloc_idx),
        .ready_vec (ready_vec),
        .fu_type   (fu_type),
        .mem_done  (mem_done),
        .issue_en  (issue_en),
        .issue_idx (issue_idx),
        .issue_fu  (issue_fu),
        .mult_busy (mult_busy),
        .mem_busy  (mem_busy)
    );

    always #5 clock = ~clock;

    task automatic drive(input logic rst, input logic intr, input logic stall,
                         input logic ae, input logic [2:0] ai, input logic [4:0] rdy,
                         input logic [9:0] fu, input logic md,
                         input logic e_en, input logic [2:0] e_idx, input logic [1:0] e_fu,
                         input logic e_mb, input logic e_memb);
        exp_t e;
        @(posedge clock);
        #1;
        reset     = rst;
        interrupt = intr;
        is_stall  = stall;
        alloc_en  = ae;
        alloc_idx = ai;
        ready_vec = rdy;
        fu_type   = fu;
        mem_done  = md;
        e.step = step_no;
        e.en   = e_en;
        e.idx  = e_idx;
        e.fu   = e_fu;
        e.mb   = e_mb;
        e.memb = e_memb;
        sb_q.push_back(e);
        step_no++;
    endtask

    task automatic check(input string name, input int step, input logic [3:0] act,
                         input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL step %0d %s: got %0h expected %0h", step, name, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("issue_en",  e.step, {3'b0, issue_en},  {3'b0, e.en});
                check("issue_idx", e.step, {1'b0, issue_idx}, {1'b0, e.idx});
                check("issue_fu",  e.step, {2'b0, issue_fu},  {2'b0, e.fu});
                check("mult_busy", e.step, {3'b0, mult_busy}, {3'b0, e.mb});
                check("mem_busy",  e.step, {3'b0, mem_busy},  {3'b0, e.memb});
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        //     rst intr stl ae  ai  rdy       fu         md    en idx fu mb memb
        drive(1, 0, 0, 0, 0, 5'b00000, C_ALU,     0,   0, 0, 0, 0, 0);
        // oldest-first: allocation order 3, 1, 4
        drive(0, 0, 0, 1, 3, 5'b00000, C_ALU,     0,   0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 5'b00000, C_ALU,     0,   0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 4, 5'b00000, C_ALU,     0,   0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 5'b11010, C_ALU,     0,   1, 3, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 5'b10010, C_ALU,     0,   1, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 5'b10000, C_ALU,     0,   1, 4, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 5'b00000, C_ALU,     0,   0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 2, 5'b00000, C_ALU,     0,   0, 0, 0, 0, 0);
        // multiplier occupancy: commit at t, next MULT waits until t+5
        drive(0, 0, 0, 0, 0, 5'b00001, C_F0_MULT, 0,   1, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 5'b00100, C_F02_MUL, 0,   0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 5'b00100, C_F02_MUL, 0,   0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 5'b00100, C_F02_MUL, 0,   0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 5'b00100, C_F02_MUL, 0,   0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 5'b00100, C_F02_MUL, 0,   1, 2, 1, 0, 0);
        // bypass: older MULT blocked, younger ALU issues
        drive(0, 0, 0, 0, 0, 5'b00101, C_F0_MULT, 0,   1, 2, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 5'b00000, C_ALU,     0,   0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 5'b00000, C_ALU,     0,   0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 5'b00000, C_ALU,     0,   0, 0, 0, 1, 0);
        // stall holds the MULT winner without committing
        drive(0, 0, 1, 0, 0, 5'b00001, C_F0_MULT, 0,   1, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0, 5'b00001, C_F0_MULT, 0,   1, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0, 5'b00001, C_F0_MULT, 0,   1, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 5'b00001, C_F0_MULT, 0,   1, 0, 1, 0, 0);
        // memory port
        drive(0, 0, 0, 0, 0, 5'b00100, C_F2_MEM,  0,   1, 2, 2, 1, 0);
        drive(0, 0, 0, 0, 0, 5'b00010, C_F1_MEM,  0,   0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 5'b00010, C_F1_MEM,  1,   0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 5'b00010, C_F1_MEM,  0,   1, 1, 2, 1, 0);
        // interrupt at mult_cnt=2 with mem_busy=1
        drive(0, 0, 0, 0, 0, 5'b00001, C_F0_MULT, 0,   1, 0, 1, 0, 1);
        drive(0, 0, 0, 0, 0, 5'b00000, C_ALU,     0,   0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 5'b00000, C_ALU,     0,   0, 0, 0, 1, 1);
        drive(0, 1, 0, 0, 0, 5'b00100, C_ALU,     0,   0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 5'b00000, C_ALU,     0,   0, 0, 0, 0, 0);
        // same scenario with synchronous reset
        drive(0, 0, 0, 0, 0, 5'b00001, C_F0_MULT, 0,   1, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 5'b00100, C_F2_MEM,  0,   1, 2, 2, 1, 0);
        drive(0, 0, 0, 0, 0, 5'b00000, C_ALU,     0,   0, 0, 0, 1, 1);
        drive(1, 0, 0, 0, 0, 5'b00000, C_ALU,     0,   0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 5'b00000, C_ALU,     0,   0, 0, 0, 0, 0);
        // re-establish order after reset; alloc and issue share a cycle
        drive(0, 0, 0, 1, 2, 5'b00000, C_ALU,     0,   0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 5'b00010, C_ALU,     0,   1, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 5'b00101, C_ALU,     0,   1, 2, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 5'b00001, C_ALU,     0,   1, 0, 0, 0, 0);
        // reserved class never issues
        drive(0, 0, 0, 0, 0, 5'b00100, C_F2_RSVD, 0,   0, 0, 0, 0, 0);

        for (int k = 0; k < 10 && sb_q.size() != 0; k++) begin
            @(negedge clock);
        end
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rs_issue_scheduler
`default_nettype wire
